// File: rtl/viterbi_decoder_k6.sv
// rtl/viterbi_decoder_k6.sv - hard-decision rate-1/2 Viterbi decoder, K=3 (7,5) or K=6 (65,57), register exchange
// Optional VITDEC_BEST_STATE_EN: emit from the best-metric state instead of path[0].
module viterbi_decoder_k6 #(
  parameter int DEPTH = 32,
  parameter int PM_W  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       choose_constraint_length,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
  output logic       out_valid,
  output logic       out_bit
);
  localparam int NS = 32;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_EMIT = CW'(DEPTH - 1);

  logic                  mode_q, mode_d;
  logic [PM_W-1:0]       pm_q [NS];
  logic [PM_W-1:0]       pm_d [NS];
  logic [DEPTH-1:0]      path_q [NS];
  logic [DEPTH-1:0]      path_d [NS];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_bit_q, out_bit_d;

  // v is {new state, oldest bit}, right-aligned; K=3 uses only v[2:0]
  function automatic logic [1:0] branch_metric(input logic mode, input logic [5:0] v,
                                               input logic [1:0] sym);
    logic [5:0] g0;
    logic [5:0] g1;
    logic [1:0] e;
    g0 = mode ? 6'o65 : 6'o07;
    g1 = mode ? 6'o57 : 6'o05;
    e  = {^(v & g0), ^(v & g1)};
    return {1'b0, sym[1] ^ e[1]} + {1'b0, sym[0] ^ e[0]};
  endfunction

  always_comb begin : acs
    logic [PM_W-1:0] pm_min;
    logic [4:0]      sn, p0, p1, psel;
    logic [5:0]      v0, v1;
    logic            in_bit;
    logic [PM_W+1:0] c0, c1, cmin, diff;
`ifdef VITDEC_BEST_STATE_EN
    logic [4:0]      best;
    logic [PM_W-1:0] best_pm;
`endif
    mode_d      = mode_q;
    pm_d        = pm_q;
    path_d      = path_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    sn = '0; p0 = '0; p1 = '0; psel = '0; v0 = '0; v1 = '0; in_bit = 1'b0;
    c0 = '0; c1 = '0; cmin = '0; diff = '0;

    pm_min = PM_MAX;
    for (int s = 0; s < NS; s++) begin
      if ((mode_q || s < 4) && pm_q[s] < pm_min) pm_min = pm_q[s];
    end

    if (in_valid) begin
      for (int s = 0; s < NS; s++) begin
        sn = 5'(s);
        if (mode_q) begin
          p0 = {sn[3:0], 1'b0};
          p1 = {sn[3:0], 1'b1};
          in_bit = sn[4];
          v0 = {sn, 1'b0};
          v1 = {sn, 1'b1};
        end else begin
          p0 = {3'b000, sn[0], 1'b0};
          p1 = {3'b000, sn[0], 1'b1};
          in_bit = sn[1];
          v0 = {3'b000, sn[1:0], 1'b0};
          v1 = {3'b000, sn[1:0], 1'b1};
        end
        c0 = {2'b00, pm_q[p0]} + {{PM_W{1'b0}}, branch_metric(mode_q, v0, in_sym)};
        c1 = {2'b00, pm_q[p1]} + {{PM_W{1'b0}}, branch_metric(mode_q, v1, in_sym)};
        // strict compare: ties keep the b=0 predecessor
        psel = (c1 < c0) ? p1 : p0;
        cmin = (c1 < c0) ? c1 : c0;
        diff = cmin - {2'b00, pm_min};
        if (mode_q || s < 4) begin
          pm_d[s]   = (diff > {2'b00, PM_MAX}) ? PM_MAX : diff[PM_W-1:0];
          path_d[s] = {path_q[psel][DEPTH-2:0], in_bit};
        end
      end

      out_valid_d = (cnt_q >= CNT_EMIT);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
`ifdef VITDEC_BEST_STATE_EN
      best    = '0;
      best_pm = pm_d[0];
      for (int s = 1; s < NS; s++) begin
        if ((mode_q || s < 4) && pm_d[s] < best_pm) begin
          best    = 5'(s);
          best_pm = pm_d[s];
        end
      end
      if (out_valid_d) out_bit_d = path_d[best][DEPTH-1];
`else
      if (out_valid_d) out_bit_d = path_d[0][DEPTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= choose_constraint_length;
      for (int s = 0; s < NS; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_MAX;
        path_q[s] <= '0;
      end
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pm_q        <= pm_d;
      path_q      <= path_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
endmodule
